glitch_sequencer: RTL and testbench
===================================

# glitch_sequencer

Arm/trigger/pulse controller that wraps the pipelined delay counter. Waits for an armed external trigger edge, loads the delay into the counter, waits for the counter's zero flag, then drives the glitch output for a programmed number of cycles. Sits directly upstream of the counter, driving its load value and load strobe, and directly downstream of it, consuming its zero flag.

## Interface
- `WIDTH_BITS`, default 16: width of the glitch pulse-length register.
- `SYNC_STAGES`, default 2: synchronizer depth on `trigger_in`, minimum 2.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arm`  in  1  one-cycle request to arm; latches the configuration.
- `abort`  in  1  return to IDLE from any state.
- `delay_value`  in  32  delay loaded into the counter.
- `pulse_width`  in  WIDTH_BITS  glitch length in cycles.
- `trig_rising`  in  1  selects the trigger edge: 1 = rising, 0 = falling.
- `trigger_in`  in  1  asynchronous external trigger.
- `counter_value`  out  32  to counter `counterValue`.
- `set_counter`  out  1  to counter `setCounter`.
- `is_zero`  in  1  from counter `isZero`.
- `glitch_out`  out  1  glitch drive, registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a glitch completes.

## Operation
- Reset values: all outputs 0, state IDLE, latched configuration 0, synchronizer flops 0.
- IDLE
  - On `arm`: latch `delay_value`, `pulse_width` and `trig_rising`, then go to ARMED.
- ARMED
  - On a selected edge from the synchronized trigger: go to LOAD.
  - Edges present before or during the arm cycle are ignored. The edge detector is re-primed on entry to ARMED.
- LOAD (1 cycle)
  - `set_counter`=1 and `counter_value`=latched delay. Then go to BLANK.
- BLANK (2 cycles)
  - `set_counter`=0. `is_zero` is ignored here to mask stale counter flags. Then go to WAIT_ZERO.
- WAIT_ZERO
  - On the first `is_zero`=1: go to PULSE if latched width is not 0, otherwise go to IDLE with `done` pulsed and no glitch.
- PULSE
  - `glitch_out`=1 for exactly the latched width in cycles, using an internal down-counter.
  - After the last high cycle, return to IDLE with `done`=1 for one cycle.
- `abort` in any state:
  - Next cycle: IDLE, `glitch_out`=0, `set_counter`=0, no `done`.
  - `abort` has priority over `arm` and over all transitions in the same cycle.
- `arm` while busy: ignored, and the latched configuration is unchanged.
- Reasserting `arm` in the same cycle as `done`: accepted, because the state is already IDLE in that cycle.
- `counter_value` holds its last loaded value outside LOAD.
- Width arithmetic: the pulse counter is WIDTH_BITS unsigned and never wraps. The maximum pulse is 2^WIDTH_BITS−1 cycles.
- Further `is_zero` assertions after leaving WAIT_ZERO are ignored. The counter wraps and re-fires periodically; that is expected.

## Timing
- Trigger path:
  - Pin to synchronized value: SYNC_STAGES cycles.
  - One further register for edge detect.
  - LOAD is entered the cycle after the edge is detected, so `set_counter` is high SYNC_STAGES+2 cycles after `trigger_in` changes, ±1 for sampling uncertainty.
- Load to earliest zero acceptance: 3 cycles (LOAD + 2 BLANK).
- `is_zero` sampled high in WAIT_ZERO → `glitch_out` rises on the next clock edge.
- `glitch_out` fall → `done` is high in that same cycle, and `busy` drops in that cycle.
- End-to-end delay from trigger to glitch equals the counter's own latency for `delay_value` plus the fixed offsets above. The sequencer applies no compensation; software calibrates.
- Reset is asynchronous on assertion: `glitch_out` drops immediately, mid-pulse included. Deassertion is synchronized externally.

## Structure
- Shared package holds:
  - the state enum: IDLE, ARMED, LOAD, BLANK, WAIT_ZERO, PULSE;
  - `BLANK_CYCLES`=2;
  - the default for `WIDTH_BITS`.
- One sub-module, `trigger_sync`: SYNC_STAGES synchronizer plus polarity-selectable edge detector with a re-prime input. Output is a one-cycle `trig_edge`.
- The sequencer contains the FSM, configuration latches, blank counter and pulse counter.

## Test plan
- Basic run:
  - Stimulus: arm with `delay_value`=10, `pulse_width`=3, rising edge; pulse `is_zero` 20 cycles after LOAD.
  - Required: `set_counter` high exactly 1 cycle with `counter_value`=10; `glitch_out` high exactly 3 cycles starting the cycle after `is_zero`; `done` is 1 cycle and `busy` then drops.
- Zero width:
  - Stimulus: `pulse_width`=0, otherwise as the basic run.
  - Required: `glitch_out` never rises; `done` pulses the cycle after `is_zero`.
- Blanking:
  - Stimulus: hold `is_zero`=1 through LOAD and BLANK.
  - Required: no glitch before WAIT_ZERO; glitch starts exactly 4 cycles after `set_counter` rises.
- Edge selection:
  - Stimulus: `trig_rising`=0, and `trigger_in` is already low at arm.
  - Required: no LOAD until a fresh falling edge; rising edges are ignored.
- Abort:
  - Stimulus: assert `abort` together with `arm`, then `abort` at the 2nd cycle of PULSE (width 8).
  - Required: first, the state stays IDLE; second, `glitch_out` is 0 next cycle, with no `done`.
- Async reset and re-arm:
  - Stimulus: drop `rst_n` mid-pulse.
  - Required: `glitch_out` is 0 without a clock edge.
  - Stimulus: after reset, arm with new values.
  - Required: the new `delay_value` appears on `counter_value` at LOAD.

Source files
------------

// File: rtl/glitch_sequencer_pkg.sv
// Shared types and constants for the glitch sequencer and its trigger front end.
package glitch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        LOAD      = 3'd2,
        BLANK     = 3'd3,
        WAIT_ZERO = 3'd4,
        PULSE     = 3'd5
    } state_t;

    localparam int unsigned BLANK_CYCLES       = 2;
    localparam int unsigned BLANK_CNT_BITS     = 2;
    localparam int unsigned DEFAULT_WIDTH_BITS = 16;
    localparam int unsigned DELAY_BITS         = 32;

endpackage

// File: rtl/glitch_sequencer_trigger_sync.sv
// Synchronizes the external trigger and flags one selected edge per transition.
// While re-prime is high the detector tracks the input but never reports an edge.
module glitch_sequencer_trigger_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_trigger,
    input  logic i_rising,
    input  logic i_reprime,
    output logic o_trig_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;
    logic                   w_synced;
    logic                   w_edge_c;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_edge_c = i_rising ? (w_synced & ~r_prev) : (~w_synced & r_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_trigger};
            r_prev <= w_synced;
            r_edge <= w_edge_c & ~i_reprime;
        end
    end

    assign o_trig_edge = r_edge;

endmodule

// File: rtl/glitch_sequencer.sv
// Arm/trigger/pulse controller: loads the delay counter on a trigger edge, waits for
// its zero flag past a blanking window, then drives glitch_out for the programmed width.
module glitch_sequencer
    import glitch_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH_BITS  = DEFAULT_WIDTH_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DELAY_BITS-1:0] delay_value,
    input  logic [WIDTH_BITS-1:0] pulse_width,
    input  logic                  trig_rising,
    input  logic                  trigger_in,
    output logic [DELAY_BITS-1:0] counter_value,
    output logic                  set_counter,
    input  logic                  is_zero,
    output logic                  glitch_out,
    output logic                  busy,
    output logic                  done
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DELAY_BITS-1:0]     r_delay;
    logic [DELAY_BITS-1:0]     w_delay_nxt;
    logic [WIDTH_BITS-1:0]     r_width;
    logic [WIDTH_BITS-1:0]     w_width_nxt;
    logic                      r_trig_rising;
    logic                      w_trig_rising_nxt;
    logic [BLANK_CNT_BITS-1:0] r_blank_cnt;
    logic [BLANK_CNT_BITS-1:0] w_blank_cnt_nxt;
    logic [WIDTH_BITS-1:0]     r_pulse_cnt;
    logic [WIDTH_BITS-1:0]     w_pulse_cnt_nxt;
    logic                      w_done_nxt;
    logic [DELAY_BITS-1:0]     r_counter_value;
    logic                      r_set_counter;
    logic                      r_glitch;
    logic                      r_busy;
    logic                      r_done;
    logic                      w_trig_edge;
    logic                      w_reprime;

    // Detector stays primed (edge-blind) everywhere except ARMED.
    assign w_reprime = (r_state != ARMED);

    glitch_sequencer_trigger_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trigger_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_trigger   (trigger_in),
        .i_rising    (r_trig_rising),
        .i_reprime   (w_reprime),
        .o_trig_edge (w_trig_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_delay_nxt       = r_delay;
        w_width_nxt       = r_width;
        w_trig_rising_nxt = r_trig_rising;
        w_blank_cnt_nxt   = r_blank_cnt;
        w_pulse_cnt_nxt   = r_pulse_cnt;
        w_done_nxt        = 1'b0;

        case (r_state)
            IDLE: begin
                if (arm && !abort) begin
                    w_delay_nxt       = delay_value;
                    w_width_nxt       = pulse_width;
                    w_trig_rising_nxt = trig_rising;
                    w_state_nxt       = ARMED;
                end
            end
            ARMED: begin
                if (w_trig_edge) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_blank_cnt_nxt = BLANK_CNT_BITS'(BLANK_CYCLES - 1);
                w_state_nxt     = BLANK;
            end
            BLANK: begin
                if (r_blank_cnt == '0) begin
                    w_state_nxt = WAIT_ZERO;
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt - BLANK_CNT_BITS'(1);
                end
            end
            WAIT_ZERO: begin
                if (is_zero) begin
                    if (r_width != '0) begin
                        w_pulse_cnt_nxt = r_width;
                        w_state_nxt     = PULSE;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            PULSE: begin
                if (r_pulse_cnt == WIDTH_BITS'(1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_pulse_cnt_nxt = r_pulse_cnt - WIDTH_BITS'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort wins over every other transition, including a same-cycle arm.
        if (abort) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay         <= '0;
            r_width         <= '0;
            r_trig_rising   <= 1'b0;
            r_blank_cnt     <= '0;
            r_pulse_cnt     <= '0;
            r_counter_value <= '0;
            r_set_counter   <= 1'b0;
            r_glitch        <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_delay       <= w_delay_nxt;
            r_width       <= w_width_nxt;
            r_trig_rising <= w_trig_rising_nxt;
            r_blank_cnt   <= w_blank_cnt_nxt;
            r_pulse_cnt   <= w_pulse_cnt_nxt;
            if (w_state_nxt == LOAD) begin
                r_counter_value <= r_delay;
            end
            r_set_counter <= (w_state_nxt == LOAD);
            r_glitch      <= (w_state_nxt == PULSE);
            r_busy        <= (w_state_nxt != IDLE);
            r_done        <= w_done_nxt;
        end
    end

    assign counter_value = r_counter_value;
    assign set_counter   = r_set_counter;
    assign glitch_out    = r_glitch;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: stimulus pushes expected load/glitch events,
// a negedge monitor pops and compares them as the outputs appear.
module tb_glitch_sequencer;

    localparam int W = 6;
    localparam int S = 3;

    logic          clk;
    logic          rst_n;
    logic          arm;
    logic          abort;
    logic [31:0]   delay_value;
    logic [W-1:0]  pulse_width;
    logic          trig_rising;
    logic          trigger_in;
    logic [31:0]   counter_value;
    logic          set_counter;
    logic          is_zero;
    logic          glitch_out;
    logic          busy;
    logic          done;

    typedef struct {
        longint dly;
        longint tcyc;
    } load_exp_t;

    typedef struct {
        longint start;
        longint len;
        longint done_cyc;
    } glitch_exp_t;

    load_exp_t   load_q[$];
    glitch_exp_t glitch_q[$];

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;

    glitch_sequencer #(
        .WIDTH_BITS  (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .abort         (abort),
        .delay_value   (delay_value),
        .pulse_width   (pulse_width),
        .trig_rising   (trig_rising),
        .trigger_in    (trigger_in),
        .counter_value (counter_value),
        .set_counter   (set_counter),
        .is_zero       (is_zero),
        .glitch_out    (glitch_out),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_glitch_out"},    longint'(glitch_out), 0);
        check({tag, "_set_counter"},   longint'(set_counter), 0);
        check({tag, "_counter_value"}, longint'(counter_value), 0);
        check({tag, "_busy"},          longint'(busy), 0);
        check({tag, "_done"},          longint'(done), 0);
    endtask

    // Monitor
    bit          prev_set;
    bit          prev_g;
    bit          prev_done;
    longint      g_start = -1;
    longint      g_len = 0;
    load_exp_t   m_le;
    glitch_exp_t m_ge;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_set  = 1'b0;
            prev_g    = 1'b0;
            prev_done = 1'b0;
            g_start   = -1;
            g_len     = 0;
        end else begin
            if (prev_set) check("set_counter_single_cycle", longint'(set_counter), 0);
            if (set_counter && !prev_set) begin
                check("load_expected", longint'(load_q.size() != 0), 1);
                if (load_q.size() != 0) begin
                    m_le = load_q.pop_front();
                    check("counter_value_at_load", longint'(counter_value), m_le.dly);
                    check_range("trigger_to_load_latency", cyc - m_le.tcyc, S + 1, S + 3);
                end
            end
            if (prev_done) check("done_single_cycle", longint'(done), 0);
            if (glitch_out) begin
                if (!prev_g) begin
                    g_start = cyc;
                    g_len   = 0;
                end
                g_len++;
            end
            if (done) begin
                check("done_expected", longint'(glitch_q.size() != 0), 1);
                if (glitch_q.size() != 0) begin
                    m_ge = glitch_q.pop_front();
                    check("glitch_start_cycle", g_start, m_ge.start);
                    check("glitch_length", g_len, m_ge.len);
                    check("done_cycle", cyc, m_ge.done_cyc);
                    check("glitch_low_at_done", longint'(glitch_out), 0);
                    check("busy_low_at_done", longint'(busy), 0);
                end
                g_start = -1;
                g_len   = 0;
            end else if (!busy) begin
                g_start = -1;
                g_len   = 0;
            end
            prev_set  = set_counter;
            prev_g    = glitch_out;
            prev_done = done;
        end
    end

    // One arm/trigger/zero transaction. kill: 0 none, 1 abort, 2 async reset (2nd pulse cycle).
    task automatic run_txn(input longint dly, input int w, input bit rise, input int extra,
                           input bit zero_held, input int lvl_sel, input int kill,
                           input bit busy_arm, input bit b2b);
        bit          lvl;
        bit          got;
        longint      l_cyc;
        longint      z;
        load_exp_t   le;
        glitch_exp_t ge;

        lvl        = (lvl_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(lvl_sel);
        trigger_in = lvl;
        is_zero    = 1'b0;
        repeat (S + 3) tick();

        delay_value = 32'(dly);
        pulse_width = W'(w);
        trig_rising = rise;
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
        delay_value = $urandom;
        pulse_width = W'($urandom);
        trig_rising = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) tick();

        if (busy_arm) begin
            arm = 1'b1;
            tick();
            arm = 1'b0;
            tick();
        end

        // Trigger parked at the post-edge level: the first toggle is the wrong edge.
        if (lvl == rise) begin
            trigger_in = ~trigger_in;
            repeat (S + 5) tick();
        end
        trigger_in = ~trigger_in;
        le.dly     = dly;
        le.tcyc    = cyc;
        load_q.push_back(le);

        got   = 1'b0;
        l_cyc = 0;
        for (int i = 0; i < S + 8 && !got; i++) begin
            tick();
            if (set_counter) begin
                got   = 1'b1;
                l_cyc = cyc;
            end
        end
        check("load_seen", longint'(got), 1);
        if (!got) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            return;
        end

        for (int i = 0; i < 3; i++) begin
            is_zero = zero_held ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        repeat (extra) begin
            is_zero = 1'b0;
            tick();
        end
        is_zero = 1'b1;
        z       = cyc;
        check("zero_offset_from_load", z - l_cyc, longint'(3 + extra));
        if (kill == 0) begin
            ge.start    = (w == 0) ? -1 : z + 1;
            ge.len      = w;
            ge.done_cyc = z + 1 + w;
            glitch_q.push_back(ge);
        end
        tick();

        if (kill != 0) begin
            is_zero = 1'b0;
            tick();
            if (kill == 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_glitch_low", longint'(glitch_out), 0);
                check("abort_no_done", longint'(done), 0);
                check("abort_busy_low", longint'(busy), 0);
            end else begin
                #2 rst_n = 1'b0;
                #1;
                check_reset_state("async_reset");
                tick();
                tick();
                rst_n = 1'b1;
                tick();
            end
        end else begin
            repeat (w) begin
                is_zero = 1'($urandom_range(0, 1));
                tick();
            end
            is_zero = 1'b0;
            if (b2b) begin
                arm = 1'b1;
                tick();
                arm = 1'b0;
                check("arm_at_done_accepted", longint'(busy), 1);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_from_armed", longint'(busy), 0);
            end else begin
                tick();
            end
        end
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
        delay_value = '0;
        pulse_width = '0;
        trig_rising = 1'b0;
        trigger_in  = 1'b0;
        is_zero     = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        run_txn(10, 3, 1'b1, 17, 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn(10, 0, 1'b1, 17, 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn(55, 5, 1'b1, 0, 1'b1, 2, 0, 1'b0, 1'b0);
        run_txn(77, 2, 1'b0, 5, 1'b0, 0, 0, 1'b0, 1'b0);

        // Abort together with arm: stays idle and a later trigger does nothing.
        trigger_in = 1'b0;
        repeat (S + 3) tick();
        delay_value = 99;
        pulse_width = W'(4);
        trig_rising = 1'b1;
        arm         = 1'b1;
        abort       = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("abort_with_arm_idle", longint'(busy), 0);
        trigger_in = 1'b1;
        repeat (S + 6) tick();
        check("abort_with_arm_still_idle", longint'(busy), 0);
        trigger_in = 1'b0;
        repeat (S + 4) tick();

        run_txn(30, 8, 1'b1, 4, 1'b0, 2, 1, 1'b0, 1'b0);
        run_txn(40, 8, 1'b1, 4, 1'b0, 2, 2, 1'b0, 1'b0);
        run_txn(1234, 2, 1'b1, 3, 1'b0, 2, 0, 1'b0, 1'b0);
        run_txn(5, 63, 1'b0, 1, 1'b0, 2, 0, 1'b1, 1'b0);
        run_txn(6, 1, 1'b1, 0, 1'b0, 2, 0, 1'b0, 1'b0);
        run_txn(321, 4, 1'b1, 2, 1'b0, 2, 0, 1'b0, 1'b1);

        for (int n = 0; n < 25; n++) begin
            int w;
            bit held;
            w    = $urandom_range(0, 10);
            if (n % 7 == 3) w = 63;
            held = ($urandom_range(0, 3) == 0);
            run_txn(longint'($urandom), w, 1'($urandom_range(0, 1)),
                    held ? 0 : int'($urandom_range(0, 12)), held, 2, 0,
                    1'($urandom_range(0, 1)), (n % 5 == 2));
        end

        repeat (5) tick();
        check("load_queue_drained", longint'(load_q.size()), 0);
        check("glitch_queue_drained", longint'(glitch_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
